// File: rtl/tone_mixer.sv
// Polyphonic tone generator: per-channel button debounce, phase-accumulator
// oscillators with a shared waveform select, and a saturating unsigned mixer.
module tone_mixer #(
    parameter int CHANNELS        = 4,
    parameter int ACC_WIDTH       = 16,
    parameter int DAC_WIDTH       = 8,
    parameter int SAMPLE_DIV      = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int MIX_SHIFT       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           button,
    input  logic [CHANNELS*ACC_WIDTH-1:0] tune,
    input  logic [1:0]                    wave_sel,
    output logic [CHANNELS-1:0]           active,
    output logic [DAC_WIDTH-1:0]          dac,
    output logic                          sample_valid
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int SUM_W = DAC_WIDTH + 3;
    localparam logic [DAC_WIDTH-1:0] DAC_MAX = '1;

    logic [CHANNELS-1:0]  sync1_reg;
    logic [CHANNELS-1:0]  sync2_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [DIV_W-1:0]     div_cnt_next;
    logic                 tick;
    logic [DAC_WIDTH-1:0] chan_sample [CHANNELS];
    logic [SUM_W-1:0]     mix_sum;
    logic [SUM_W-1:0]     mix_shifted;
    logic [DAC_WIDTH-1:0] mix_next;
    logic [DAC_WIDTH-1:0] dac_reg;
    logic                 valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= button;
            sync2_reg <= sync1_reg;
        end
    end

    assign tick         = (div_cnt_reg == DIV_W'(SAMPLE_DIV - 1));
    assign div_cnt_next = tick ? '0 : div_cnt_reg + DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [DB_W-1:0]      db_cnt_reg;
            logic                 active_bit_reg;
            logic [ACC_WIDTH-1:0] acc_reg;
            logic [DAC_WIDTH-1:0] saw_val;
            logic [DAC_WIDTH-1:0] tri_val;
            logic                 msb;
            logic                 acc_unused;

            // Counter only runs while the synchronised input disagrees with
            // the debounced state, so any shorter glitch simply clears it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    db_cnt_reg     <= '0;
                    active_bit_reg <= 1'b0;
                end else if (sync2_reg[gi] == active_bit_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt_reg     <= '0;
                    active_bit_reg <= ~active_bit_reg;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DB_W'(1);
                end
            end

            // Idle channels sit at phase 0 so every press starts a clean note.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (!active_bit_reg) begin
                    acc_reg <= '0;
                end else if (tick) begin
                    acc_reg <= acc_reg + tune[gi*ACC_WIDTH +: ACC_WIDTH];
                end
            end

            assign msb        = acc_reg[ACC_WIDTH-1];
            assign saw_val    = acc_reg[ACC_WIDTH-1 -: DAC_WIDTH];
            assign tri_val    = acc_reg[ACC_WIDTH-2 -: DAC_WIDTH] ^ {DAC_WIDTH{msb}};
            assign acc_unused = ^acc_reg;

            always_comb begin
                chan_sample[gi] = '0;
                if (active_bit_reg) begin
                    case (wave_sel)
                        2'b00:   chan_sample[gi] = msb ? DAC_MAX : '0;
                        2'b01:   chan_sample[gi] = saw_val;
                        2'b10:   chan_sample[gi] = tri_val;
                        default: chan_sample[gi] = '0;
                    endcase
                end
            end

            assign active[gi] = active_bit_reg;
        end
    endgenerate

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_sum = mix_sum + SUM_W'(chan_sample[i]);
        end
        mix_shifted = mix_sum >> MIX_SHIFT;
        if (mix_shifted > SUM_W'(DAC_MAX)) begin
            mix_next = DAC_MAX;
        end else begin
            mix_next = mix_shifted[DAC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= tick;
            if (tick) begin
                dac_reg <= mix_next;
            end
        end
    end

    assign dac          = dac_reg;
    assign sample_valid = valid_reg;

endmodule

// File: tb/tb_tone_mixer.sv
// Directed bench for tone_mixer: reset, debounce timing, sawtooth, square
// chord with saturation, triangle with release/re-press, async reset mid-note.
module tb_tone_mixer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  button = '0;
    logic [63:0] tune = '0;
    logic [1:0]  wave_sel = '0;
    logic [3:0]  active, active_b;
    logic [7:0]  dac, dac_b;
    logic        sample_valid, sample_valid_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tone_mixer dut (
        .clk(clk), .rst_n(rst_n), .button(button), .tune(tune),
        .wave_sel(wave_sel), .active(active), .dac(dac),
        .sample_valid(sample_valid)
    );

    // Same stimulus, no mix shift: exercises the saturation path.
    tone_mixer #(.MIX_SHIFT(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .button(button), .tune(tune),
        .wave_sel(wave_sel), .active(active_b), .dac(dac_b),
        .sample_valid(sample_valid_b)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        button = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_active(input logic [3:0] want, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while ((active !== want || active_b !== want) && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (active === want && active_b === want);
    endtask

    task automatic get_sample(output logic [7:0] d, output logic [7:0] d_b, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (sample_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        ok  = (sample_valid === 1'b1);
        d   = dac;
        d_b = dac_b;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        button = 4'hF;
        repeat (3) @(negedge clk);
        $display("reset held: dac=%0d active=%b valid=%b", dac, active, sample_valid);
        n_checks++;
        if (dac !== 8'd0) begin n_fail++; $display("FAIL reset_dac got=%0d want=0", dac); end
        n_checks++;
        if (active !== 4'b0) begin n_fail++; $display("FAIL reset_active got=%b want=0000", active); end
        n_checks++;
        if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", sample_valid); end
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            $display("post-reset edge %0d: valid=%b", k, sample_valid);
            n_checks++;
            if (sample_valid !== (k == 4)) begin
                n_fail++;
                $display("FAIL first_tick edge=%0d got=%b want=%b", k, sample_valid, (k == 4));
            end
        end
        n_checks++;
        if (dac !== 8'd0) begin n_fail++; $display("FAIL first_sample_dac got=%0d want=0", dac); end
    endtask

    task automatic test_debounce();
        do_reset();
        @(negedge clk);
        button = 4'b0001;
        repeat (5) @(negedge clk);
        button = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (active[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch cycle=%0d active0=%b want=0", k, active[0]);
            end
        end
        $display("glitch of 5 cycles: active0=%b", active[0]);
        button = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            $display("press edge %0d: active0=%b", k, active[0]);
            n_checks++;
            if (active[0] !== (k == 10)) begin
                n_fail++;
                $display("FAIL debounce_latency edge=%0d got=%b want=%b", k, active[0], (k == 10));
            end
        end
    endtask

    task automatic test_sawtooth();
        logic [7:0] d, db, exp_d, exp_db;
        bit ok;
        do_reset();
        tune     = 64'h0000_0000_0000_1000;
        wave_sel = 2'b01;
        button   = 4'b0001;
        wait_active(4'b0001, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL saw_activate got=%b want=0001", active); end
        for (int k = 0; k < 17; k++) begin
            get_sample(d, db, ok);
            exp_d  = 8'((k % 16) * 4);
            exp_db = 8'((k % 16) * 16);
            $display("saw sample %0d: dac=%0d dac_noshift=%0d", k, d, db);
            n_checks++;
            if (!ok || d !== exp_d) begin
                n_fail++;
                $display("FAIL saw k=%0d got=%0d want=%0d valid=%b", k, d, exp_d, ok);
            end
            n_checks++;
            if (!ok || db !== exp_db) begin
                n_fail++;
                $display("FAIL saw_noshift k=%0d got=%0d want=%0d", k, db, exp_db);
            end
        end
    endtask

    task automatic test_square_chord();
        logic [7:0] d, db, exp_d;
        bit ok;
        do_reset();
        tune     = {4{16'h8000}};
        wave_sel = 2'b00;
        button   = 4'b1111;
        wait_active(4'b1111, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL square_activate got=%b want=1111", active); end
        for (int k = 0; k < 6; k++) begin
            get_sample(d, db, ok);
            exp_d = (k % 2 == 1) ? 8'd255 : 8'd0;
            $display("square sample %0d: dac=%0d dac_noshift=%0d", k, d, db);
            n_checks++;
            if (!ok || d !== exp_d) begin
                n_fail++;
                $display("FAIL square k=%0d got=%0d want=%0d", k, d, exp_d);
            end
            n_checks++;
            if (!ok || sample_valid_b !== 1'b1 || db !== exp_d) begin
                n_fail++;
                $display("FAIL square_sat k=%0d got=%0d want=%0d", k, db, exp_d);
            end
        end
        wave_sel = 2'b11;
        for (int k = 0; k < 2; k++) begin
            get_sample(d, db, ok);
            $display("silence sample %0d: dac=%0d dac_noshift=%0d", k, d, db);
            n_checks++;
            if (!ok || d !== 8'd0 || db !== 8'd0) begin
                n_fail++;
                $display("FAIL silence k=%0d got=%0d/%0d want=0/0", k, d, db);
            end
        end
    endtask

    task automatic test_triangle_release();
        logic [7:0] d, db;
        logic [7:0] tri_exp [9];
        bit ok;
        tri_exp = '{8'd0, 8'd16, 8'd32, 8'd48, 8'd63, 8'd47, 8'd31, 8'd15, 8'd0};
        do_reset();
        tune     = 64'h0000_0000_2000_0000;
        wave_sel = 2'b10;
        button   = 4'b0010;
        wait_active(4'b0010, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL tri_activate got=%b want=0010", active); end
        for (int k = 0; k < 9; k++) begin
            get_sample(d, db, ok);
            $display("tri sample %0d: dac=%0d", k, d);
            n_checks++;
            if (!ok || d !== tri_exp[k]) begin
                n_fail++;
                $display("FAIL tri k=%0d got=%0d want=%0d", k, d, tri_exp[k]);
            end
        end
        for (int k = 1; k < 3; k++) begin
            get_sample(d, db, ok);
            $display("tri ramp sample %0d: dac=%0d", k, d);
            n_checks++;
            if (!ok || d !== tri_exp[k]) begin
                n_fail++;
                $display("FAIL tri_ramp k=%0d got=%0d want=%0d", k, d, tri_exp[k]);
            end
        end
        button = 4'b0000;
        wait_active(4'b0000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL tri_release got=%b want=0000", active); end
        get_sample(d, db, ok);
        $display("released sample: dac=%0d", d);
        n_checks++;
        if (!ok || d !== 8'd0) begin n_fail++; $display("FAIL tri_released got=%0d want=0", d); end
        button = 4'b0010;
        wait_active(4'b0010, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL tri_repress got=%b want=0010", active); end
        for (int k = 0; k < 3; k++) begin
            get_sample(d, db, ok);
            $display("re-press sample %0d: dac=%0d", k, d);
            n_checks++;
            if (!ok || d !== tri_exp[k]) begin
                n_fail++;
                $display("FAIL tri_restart k=%0d got=%0d want=%0d", k, d, tri_exp[k]);
            end
        end
    endtask

    task automatic test_async_reset_mid_note();
        logic [7:0] d, db;
        logic [7:0] mix_exp [4];
        bit ok;
        mix_exp = '{8'd0, 8'd28, 8'd56, 8'd84};
        do_reset();
        tune     = 64'h0000_4000_2000_1000;
        wave_sel = 2'b01;
        button   = 4'b0111;
        for (int pass = 0; pass < 2; pass++) begin
            wait_active(4'b0111, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL chord_activate pass=%0d got=%b", pass, active); end
            for (int k = 0; k < 4; k++) begin
                get_sample(d, db, ok);
                $display("chord pass %0d sample %0d: dac=%0d", pass, k, d);
                n_checks++;
                if (!ok || d !== mix_exp[k]) begin
                    n_fail++;
                    $display("FAIL chord pass=%0d k=%0d got=%0d want=%0d", pass, k, d, mix_exp[k]);
                end
            end
            if (pass == 0) begin
                #2 rst_n = 1'b0;
                #1;
                $display("async reset: dac=%0d active=%b valid=%b", dac, active, sample_valid);
                n_checks++;
                if (dac !== 8'd0 || active !== 4'b0 || sample_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL async_reset dac=%0d active=%b valid=%b want=0/0000/0",
                             dac, active, sample_valid);
                end
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                for (int k = 1; k <= 4; k++) begin
                    @(posedge clk);
                    #1;
                    n_checks++;
                    if (sample_valid !== (k == 4)) begin
                        n_fail++;
                        $display("FAIL resume_tick edge=%0d got=%b want=%b", k, sample_valid, (k == 4));
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce();
        test_sawtooth();
        test_square_chord();
        test_triangle_release();
        test_async_reset_mid_note();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
